// File: rtl/scene_compositor.sv
// scene_compositor: double-buffered sphere descriptor table with a pipelined
// nearest-hit resolve tree producing one composited pixel colour per clock.
module scene_compositor #(
  parameter int NUM_SPHERES = 4,
  parameter int COORD_W = 24,
  parameter int DIST_W = 24,
  parameter logic [31:0] BG_COLOR = 32'h00000000,
  localparam int IW = NUM_SPHERES > 1 ? $clog2(NUM_SPHERES) : 1
) (
  input  logic                           pixel_clk,
  input  logic                           rst_n,
  input  logic                           vsync,
  input  logic                           cfg_we,
  input  logic [IW-1:0]                  cfg_idx,
  input  logic [2:0]                     cfg_field,
  input  logic [31:0]                    cfg_data,
  output logic [NUM_SPHERES*COORD_W-1:0] sphere_x,
  output logic [NUM_SPHERES*COORD_W-1:0] sphere_y,
  output logic [NUM_SPHERES*COORD_W-1:0] sphere_z,
  output logic [NUM_SPHERES*COORD_W-1:0] sphere_radius,
  input  logic                           hit_valid,
  input  logic [NUM_SPHERES-1:0]         hit,
  input  logic [NUM_SPHERES*DIST_W-1:0]  hit_dist,
  output logic                           pixel_valid,
  output logic [31:0]                    pixel_data,
  output logic [IW-1:0]                  pixel_id,
  output logic                           pixel_hit
);
  localparam int LV = $clog2(NUM_SPHERES);
  localparam int P = 1 << LV;
  logic [COORD_W-1:0] sx [NUM_SPHERES], sy [NUM_SPHERES], sz [NUM_SPHERES], sr [NUM_SPHERES];
  logic [COORD_W-1:0] ax [NUM_SPHERES], ay [NUM_SPHERES], az [NUM_SPHERES], ar [NUM_SPHERES];
  logic [31:0] sc [NUM_SPHERES], ac [NUM_SPHERES];
  logic [NUM_SPHERES-1:0] sen, aen;
  logic vsync_q, swap;
  logic e_h [P];
  logic [DIST_W-1:0] e_d [P];
  logic [31:0] e_c [P];
  logic [LV:0] tv;
  logic th [LV+1][P];
  logic [DIST_W-1:0] td [LV+1][P];
  logic [IW-1:0] tid [LV+1][P];
  logic [31:0] tc [LV+1][P];
  assign swap = vsync & ~vsync_q;
  always_ff @(posedge pixel_clk or negedge rst_n)
    if (!rst_n) begin
      sx <= '{default: '0};
      sy <= '{default: '0};
      sz <= '{default: '0};
      sr <= '{default: '0};
      sc <= '{default: '0};
      sen <= '0;
    end else if (cfg_we && int'(cfg_idx) < NUM_SPHERES) begin
      case (cfg_field)
        3'd0: sx[cfg_idx] <= cfg_data[COORD_W-1:0];
        3'd1: sy[cfg_idx] <= cfg_data[COORD_W-1:0];
        3'd2: sz[cfg_idx] <= cfg_data[COORD_W-1:0];
        3'd3: sr[cfg_idx] <= cfg_data[COORD_W-1:0];
        3'd4: sc[cfg_idx] <= cfg_data;
        3'd5: sen[cfg_idx] <= cfg_data[0];
        default: ;
      endcase
    end
  // The copy samples shadow before any same-cycle write lands.
  always_ff @(posedge pixel_clk or negedge rst_n)
    if (!rst_n) begin
      ax <= '{default: '0};
      ay <= '{default: '0};
      az <= '{default: '0};
      ar <= '{default: '0};
      ac <= '{default: '0};
      aen <= '0;
      vsync_q <= 1'b0;
    end else begin
      vsync_q <= vsync;
      if (swap) begin
        ax <= sx;
        ay <= sy;
        az <= sz;
        ar <= sr;
        ac <= sc;
        aen <= sen;
      end
    end
  for (genvar i = 0; i < NUM_SPHERES; i++) begin : g_out
    assign sphere_x[i*COORD_W +: COORD_W] = ax[i];
    assign sphere_y[i*COORD_W +: COORD_W] = ay[i];
    assign sphere_z[i*COORD_W +: COORD_W] = az[i];
    assign sphere_radius[i*COORD_W +: COORD_W] = ar[i];
  end
  for (genvar i = 0; i < P; i++) begin : g_in
    if (i < NUM_SPHERES) begin : g_s
      assign e_h[i] = hit[i] & aen[i];
      assign e_d[i] = hit_dist[i*DIST_W +: DIST_W];
      assign e_c[i] = ac[i];
    end else begin : g_pad
      assign e_h[i] = 1'b0;
      assign e_d[i] = '0;
      assign e_c[i] = '0;
    end
  end
  // Left operand always carries the lower ids, so ties and double misses keep it.
  function automatic logic right_wins(input logic hl, input logic [DIST_W-1:0] dl,
                                      input logic hr, input logic [DIST_W-1:0] dr);
    return hr && (!hl || dr < dl);
  endfunction
  always_ff @(posedge pixel_clk or negedge rst_n)
    if (!rst_n) begin
      tv <= '0;
      for (int k = 0; k <= LV; k++)
        for (int j = 0; j < P; j++) begin
          th[k][j] <= 1'b0;
          td[k][j] <= '0;
          tid[k][j] <= '0;
          tc[k][j] <= '0;
        end
    end else begin
      tv[0] <= hit_valid;
      for (int i = 0; i < P; i++) begin
        th[0][i] <= e_h[i];
        td[0][i] <= e_d[i];
        tid[0][i] <= IW'(i);
        tc[0][i] <= e_c[i];
      end
      for (int k = 0; k < LV; k++) begin
        tv[k+1] <= tv[k];
        for (int j = 0; j < (P >> (k + 1)); j++) begin
          th[k+1][j] <= th[k][2*j] | th[k][2*j+1];
          td[k+1][j] <= right_wins(th[k][2*j], td[k][2*j], th[k][2*j+1], td[k][2*j+1]) ? td[k][2*j+1] : td[k][2*j];
          tid[k+1][j] <= right_wins(th[k][2*j], td[k][2*j], th[k][2*j+1], td[k][2*j+1]) ? tid[k][2*j+1] : tid[k][2*j];
          tc[k+1][j] <= right_wins(th[k][2*j], td[k][2*j], th[k][2*j+1], td[k][2*j+1]) ? tc[k][2*j+1] : tc[k][2*j];
        end
      end
    end
  always_ff @(posedge pixel_clk or negedge rst_n)
    if (!rst_n) begin
      pixel_valid <= 1'b0;
      pixel_data <= BG_COLOR;
      pixel_id <= '0;
      pixel_hit <= 1'b0;
    end else begin
      pixel_valid <= tv[LV];
      if (tv[LV]) begin
        pixel_hit <= th[LV][0];
        pixel_id <= th[LV][0] ? tid[LV][0] : '0;
        pixel_data <= th[LV][0] ? tc[LV][0] : BG_COLOR;
      end
    end
endmodule

// File: tb/tb_scene_compositor.sv
// tb_scene_compositor: randomized and directed checks of scene_compositor
// against a linear-scan nearest-hit model with a latency-tagged expectation queue.
module tb_scene_compositor;
  logic pixel_clk = 0, rst_n = 1, vsync = 0, cfg_we = 0, hit_valid = 0;
  logic [1:0] cfg_idx = 0;
  logic [2:0] cfg_field = 0;
  logic [31:0] cfg_data = 0;
  logic [3:0] hit = 0;
  logic [95:0] hit_dist = 0;
  logic [95:0] sphere_x, sphere_y, sphere_z, sphere_radius;
  logic pixel_valid, pixel_hit;
  logic [31:0] pixel_data;
  logic [1:0] pixel_id;
  int passed = 0, total = 0;

  scene_compositor dut (
    .pixel_clk(pixel_clk), .rst_n(rst_n), .vsync(vsync), .cfg_we(cfg_we),
    .cfg_idx(cfg_idx), .cfg_field(cfg_field), .cfg_data(cfg_data),
    .sphere_x(sphere_x), .sphere_y(sphere_y), .sphere_z(sphere_z),
    .sphere_radius(sphere_radius), .hit_valid(hit_valid), .hit(hit),
    .hit_dist(hit_dist), .pixel_valid(pixel_valid), .pixel_data(pixel_data),
    .pixel_id(pixel_id), .pixel_hit(pixel_hit)
  );

  always #5 pixel_clk = ~pixel_clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  typedef struct { int due; logic h; logic [1:0] id; logic [31:0] d; } exp_t;
  exp_t q[$];
  logic [23:0] m_sx [4], m_sy [4], m_sz [4], m_sr [4], m_ax [4], m_ay [4], m_az [4], m_ar [4];
  logic [31:0] m_sc [4], m_ac [4];
  logic [3:0] m_sen, m_aen;
  logic m_vq;
  int ecnt = 0;
  logic [31:0] last_d = 0;
  logic [1:0] last_id = 0;
  logic last_h = 0;

  function automatic logic [95:0] pk(input logic [23:0] a [4]);
    logic [95:0] r;
    for (int i = 0; i < 4; i++) r[i*24 +: 24] = a[i];
    return r;
  endfunction

  always @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        m_sx[i] = 0; m_sy[i] = 0; m_sz[i] = 0; m_sr[i] = 0; m_sc[i] = 0;
        m_ax[i] = 0; m_ay[i] = 0; m_az[i] = 0; m_ar[i] = 0; m_ac[i] = 0;
      end
      m_sen = 0; m_aen = 0; m_vq = 0; ecnt = 0;
      q.delete();
      last_d = 0; last_id = 0; last_h = 0;
    end else begin
      ecnt++;
      if (hit_valid) begin
        exp_t e;
        logic [23:0] bd;
        e.due = ecnt + 3; e.h = 0; e.id = 0; e.d = 32'h0; bd = 0;
        for (int i = 0; i < 4; i++)
          if (hit[i] && m_aen[i] && (!e.h || hit_dist[i*24 +: 24] < bd)) begin
            e.h = 1; e.id = 2'(i); e.d = m_ac[i]; bd = hit_dist[i*24 +: 24];
          end
        q.push_back(e);
      end
      if (vsync && !m_vq) begin
        m_ax = m_sx; m_ay = m_sy; m_az = m_sz; m_ar = m_sr; m_ac = m_sc; m_aen = m_sen;
      end
      m_vq = vsync;
      if (cfg_we)
        case (cfg_field)
          3'd0: m_sx[cfg_idx] = cfg_data[23:0];
          3'd1: m_sy[cfg_idx] = cfg_data[23:0];
          3'd2: m_sz[cfg_idx] = cfg_data[23:0];
          3'd3: m_sr[cfg_idx] = cfg_data[23:0];
          3'd4: m_sc[cfg_idx] = cfg_data;
          3'd5: m_sen[cfg_idx] = cfg_data[0];
          default: ;
        endcase
    end
  end

  always @(negedge pixel_clk) if (rst_n) begin
    chk("sphere_x", sphere_x, pk(m_ax));
    chk("sphere_y", sphere_y, pk(m_ay));
    chk("sphere_z", sphere_z, pk(m_az));
    chk("sphere_radius", sphere_radius, pk(m_ar));
    if (q.size() > 0 && q[0].due == ecnt) begin
      exp_t e;
      e = q.pop_front();
      chk("pixel_valid", pixel_valid, 1'b1);
      chk("pixel_data", pixel_data, e.d);
      chk("pixel_id", pixel_id, e.id);
      chk("pixel_hit", pixel_hit, e.h);
      last_d = e.d; last_id = e.id; last_h = e.h;
    end else begin
      chk("pixel_idle", pixel_valid, 1'b0);
      chk("hold_data", pixel_data, last_d);
      chk("hold_id", pixel_id, last_id);
      chk("hold_hit", pixel_hit, last_h);
    end
  end

  task automatic wr(input int idx, input int f, input logic [31:0] d);
    cfg_we = 1; cfg_idx = 2'(idx); cfg_field = 3'(f); cfg_data = d;
    @(negedge pixel_clk);
    cfg_we = 0;
  endtask

  task automatic do_swap();
    vsync = 1;
    @(negedge pixel_clk);
    vsync = 0;
    @(negedge pixel_clk);
  endtask

  task automatic px(input logic [3:0] h, input logic [95:0] d);
    hit_valid = 1; hit = h; hit_dist = d;
    @(negedge pixel_clk);
    hit_valid = 0;
    repeat (3) @(negedge pixel_clk);
  endtask

  logic [31:0] cols [4] = '{32'hff0000ff, 32'h00ff00ff, 32'h0000ffff, 32'hffffffff};
  logic [95:0] dists;

  initial begin
    dists = {24'd3, 24'd3, 24'd9, 24'd5};
    #1 rst_n = 0;
    #1;
    chk("rst_valid", pixel_valid, 1'b0);
    chk("rst_data", pixel_data, 32'h0);
    chk("rst_id", pixel_id, 2'd0);
    chk("rst_sphere_x", sphere_x, 96'h0);
    repeat (2) @(negedge pixel_clk);
    rst_n = 1;
    @(negedge pixel_clk);
    wr(2, 0, 32'h001000);
    chk("shadow_hidden", sphere_x[48 +: 24], 24'h0);
    vsync = 1;
    @(negedge pixel_clk);
    chk("swap_x", sphere_x[48 +: 24], 24'h001000);
    wr(2, 0, 32'h002000);
    repeat (9) @(negedge pixel_clk);
    chk("vsync_held", sphere_x[48 +: 24], 24'h001000);
    vsync = 0;
    @(negedge pixel_clk);
    vsync = 1;
    wr(1, 3, 32'h000800);
    chk("coincident_r", sphere_radius[24 +: 24], 24'h0);
    vsync = 0;
    @(negedge pixel_clk);
    chk("coincident_wait", sphere_radius[24 +: 24], 24'h0);
    vsync = 1;
    @(negedge pixel_clk);
    vsync = 0;
    chk("coincident_next", sphere_radius[24 +: 24], 24'h000800);
    @(negedge pixel_clk);
    for (int i = 0; i < 4; i++) begin
      wr(i, 4, cols[i]);
      wr(i, 5, 32'h1);
    end
    wr(0, 6, 32'h0);
    wr(3, 7, 32'h0);
    do_swap();
    px(4'b1110, dists);
    chk("near_valid", pixel_valid, 1'b1);
    chk("near_id", pixel_id, 2'd2);
    chk("near_data", pixel_data, 32'h0000ffff);
    chk("near_hit", pixel_hit, 1'b1);
    wr(2, 5, 32'h0);
    do_swap();
    px(4'b1110, dists);
    chk("dis_id", pixel_id, 2'd3);
    chk("dis_data", pixel_data, 32'hffffffff);
    px(4'b0000, dists);
    chk("miss_data", pixel_data, 32'h0);
    chk("miss_hit", pixel_hit, 1'b0);
    chk("miss_id", pixel_id, 2'd0);
    for (int i = 0; i < 4; i++) begin
      wr(i, 4, ~cols[i]);
      wr(i, 5, 32'h1);
    end
    for (int n = 0; n < 20; n++) begin
      if (n >= 4) chk("stream_valid", pixel_valid, 1'b1);
      if (n < 16) begin
        hit_valid = 1; hit = 4'(n); vsync = (n == 8);
        for (int i = 0; i < 4; i++) hit_dist[i*24 +: 24] = 24'($urandom_range(0, 7));
      end else begin
        hit_valid = 0; vsync = 0;
      end
      @(negedge pixel_clk);
    end
    for (int n = 0; n < 400; n++) begin
      cfg_we = ($urandom_range(0, 1) == 1); cfg_idx = 2'($urandom);
      cfg_field = 3'($urandom); cfg_data = $urandom;
      vsync = ($urandom_range(0, 9) == 0);
      hit_valid = ($urandom_range(0, 3) != 0); hit = 4'($urandom);
      for (int i = 0; i < 4; i++) hit_dist[i*24 +: 24] = 24'($urandom_range(0, 7));
      @(negedge pixel_clk);
    end
    cfg_we = 0; vsync = 0; hit_valid = 1; hit = 4'hf;
    repeat (3) @(negedge pixel_clk);
    #2 rst_n = 0;
    #1;
    chk("mid_rst_valid", pixel_valid, 1'b0);
    chk("mid_rst_data", pixel_data, 32'h0);
    chk("mid_rst_id", pixel_id, 2'd0);
    chk("mid_rst_spheres", {sphere_x, sphere_y, sphere_z, sphere_radius} == 384'h0, 1'b1);
    @(negedge pixel_clk);
    hit_valid = 0;
    rst_n = 1;
    repeat (6) @(negedge pixel_clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/scene_compositor.md
Name: scene_compositor

Overview:
Parametrised multi-sphere successor to the single-sphere scene stage. It holds a double-buffered table of NUM_SPHERES sphere descriptors, each with centre, radius, colour and enable. The active bank drives the per-sphere intersection units, and the shadow bank swaps in at the start of vertical sync. It then depth-resolves the per-sphere hit results for each pixel through a pipelined nearest-hit tree and emits the pixel colour.

Parameters:
NUM_SPHERES, 4, number of sphere slots (1..16)
COORD_W, 24, fixed-point width of x/y/z/radius
DIST_W, 24, fixed-point width of hit distance (unsigned)
BG_COLOR, 32'h00000000, colour output when no enabled sphere is hit

Ports:
pixel_clk  in  1  pixel clock; all logic is on its rising edge
rst_n  in  1  asynchronous active-low reset
vsync  in  1  vertical sync from timing generator
cfg_we  in  1  write strobe into the shadow bank
cfg_idx  in  IW=max(1,$clog2(NUM_SPHERES))  sphere slot to write
cfg_field  in  3  0=x 1=y 2=z 3=radius 4=colour 5=enable; 6,7 reserved
cfg_data  in  32  write data; low COORD_W bits for x/y/z/radius, bit0 for enable
sphere_x, sphere_y, sphere_z, sphere_radius  out  NUM_SPHERES*COORD_W each  active-bank descriptors; slot i in bits [i*COORD_W +: COORD_W]
hit_valid  in  1  qualifies hit/hit_dist for one pixel
hit  in  NUM_SPHERES  per-sphere intersects flag
hit_dist  in  NUM_SPHERES*DIST_W  per-sphere distance along ray; slot i packed as above
pixel_valid  out  1  pixel_data/pixel_id/pixel_hit are valid
pixel_data  out  32  resolved colour
pixel_id  out  IW  index of winning sphere
pixel_hit  out  1  an enabled sphere was hit

Behaviour:
Reset:
- Both banks clear: coordinates, radius and colour are 0; all enables are 0.
- pixel_valid=0, pixel_data=BG_COLOR, pixel_id=0, pixel_hit=0.
- Registered vsync copy is 0.
- All pipeline valid bits clear immediately; in-flight pixels are dropped.

Config writes:
- cfg_we=1 updates shadow[cfg_idx].field on the next edge.
- cfg_idx >= NUM_SPHERES or a reserved field: the write is ignored.
- The active bank is never written directly.

Bank swap:
- A vsync rising edge (vsync=1, registered vsync=0) copies shadow to active on that edge.
- sphere_* outputs reflect the new values the cycle after.
- Shadow keeps its contents after the swap; it is not cleared.
- A cfg write in the same cycle as the swap lands in shadow only; the copy uses pre-write shadow values, so the write takes effect at the next frame.
- vsync held high gives exactly one swap.

Resolve pipeline:
- Stage 0 registers hit_valid and, per slot, eff_hit = hit[i] & active_enable[i], hit_dist[i], and active colour[i].
- Colour and enable are therefore sampled at entry; a swap mid-pipeline does not alter in-flight pixels.
- A binary min-tree follows with one register stage per level: ceil(log2 NUM_SPHERES) levels.
- Each node keeps (hit, dist, id, colour). A hit beats a miss. Between two hits the smaller dist wins. On equal dist the lower id wins. Two misses keep the left operand.
- The output stage registers pixel_valid, pixel_hit and pixel_id, and sets pixel_data = colour on a hit, else BG_COLOR.
- Latency L = ceil(log2 NUM_SPHERES) + 2 cycles from hit_valid to pixel_valid (L=4 for the default, L=2 for NUM_SPHERES=1).
- Throughput is one pixel per clock, with no back-pressure.
- Non-power-of-two N pads the tree with miss entries.
- Outputs hold their last values while pixel_valid=0.
- On a miss, pixel_id=0 and pixel_hit=0.

Test Plan:
- Reset values: assert rst_n=0 with hit_valid=1 mid-stream -> on the same cycle, pixel_valid=0, pixel_data=32'h0, pixel_id=0, all sphere_* outputs 0.
- Shadow/swap: write slot 2 x=24'h001000 with vsync=0 -> sphere_x slot 2 stays 0. Pulse vsync -> slot 2 reads 24'h001000 one cycle after the rising edge. Hold vsync high for 10 cycles -> no further change.
- Write coincident with swap: write slot 1 radius=24'h000800 in the same cycle as the vsync rising edge -> active radius is unchanged. It appears after the next vsync rising edge.
- Nearest hit: enable slots 0..3 with colours 32'hff0000ff, 32'h00ff00ff, 32'h0000ffff, 32'hffffffff. Drive hit=4'b1110 with dists 5,9,3,3 -> after 4 cycles, pixel_id=2, pixel_data=32'h0000ffff, pixel_hit=1 (tie resolved to the lower id).
- Disable and miss: clear enable for slot 2 and swap, then repeat the previous stimulus -> pixel_id=3, colour 32'hffffffff. Drive hit=0 -> pixel_data=BG_COLOR, pixel_hit=0, pixel_id=0.
- Streaming: send 16 back-to-back pixels with distinct hit patterns while a swap occurs on pixel 8 -> 16 consecutive valid outputs at latency 4. Pixels 0..8 use the old colours and 9..15 the new ones; no bubbles.
